// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared owner encodings, BCD limits and clamp helper
package clock_pkg;

  // Owner encodings double as the scheduler FSM state codes
  localparam logic [1:0] OWN_SEC   = 2'd0;
  localparam logic [1:0] OWN_SET   = 2'd1;
  localparam logic [1:0] OWN_ALARM = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Sweep direction of the alarm animation
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Saturate an out-of-range BCD digit to the top of the bar
  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// rtl/blink_gen.sv - tick-driven blink phase toggle with synchronous clear
module blink_gen #(
  parameter int BLINK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic tick_i,
  output logic blink
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          blink_q, blink_d;

  // blink is the look-ahead phase so the parent can register it alongside
  // its other outputs without an extra cycle of lag
  assign blink = blink_d;

  // Count ticks; every BLINK_DIV-th tick flips the phase, clear wins over tick
  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (clr_i) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (tick_i) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Phase and divider registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

endmodule

// File: rtl/led_bar_scheduler.sv
// rtl/led_bar_scheduler.sv - arbitrates the LED bar between seconds, set-mode and alarm sweep
module led_bar_scheduler
  import clock_pkg::*;
#(
  parameter int HOLD_TICKS = 3,
  parameter int BLINK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] sec_ones,
  input  logic       set_req,
  input  logic [3:0] set_val,
  input  logic       alarm_req,
  output logic [3:0] bar_bcd,
  output logic       bar_en,
  output logic [1:0] owner,
  output logic       alarm_ack
);

  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          set_req_q;
  logic [3:0]    bar_bcd_q, bar_bcd_d;
  logic          bar_en_q, bar_en_d;
  logic          ack_q, ack_d;
  logic          blink_clr;
  logic          blink;

  // Blink phase only runs while SET is held; any entry restarts it at "lit"
  assign blink_clr = (state_d != OWN_SET) || (state_q != OWN_SET);

  blink_gen #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (blink_clr),
    .tick_i(tick),
    .blink (blink)
  );

  // Ownership FSM: sweep, hold and exit handling, then alarm preemption
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    ack_d   = 1'b0;
    case (state_q)
      OWN_ALARM: begin
        if (tick) begin
          if (dir_q == DIR_UP) begin
            if (cnt_q >= BCD_MAX) begin
              dir_d = DIR_DOWN;
              cnt_d = BCD_MAX - 4'd1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (alarm_req) begin
            dir_d = DIR_UP;
            cnt_d = 4'd1;
          end else begin
            // Sweep finished at the bottom with no alarm pending
            ack_d   = 1'b1;
            state_d = set_req ? OWN_SET : OWN_SEC;
          end
        end
      end
      OWN_SET: begin
        if (set_req) begin
          hold_d = '0;
        end else if (set_req_q) begin
          // Falling edge arms the hold; takes precedence over exit checks
          hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
          if (tick) hold_d = hold_q - 1'b1;
        end else begin
          state_d = OWN_SEC;
        end
      end
      default: begin
        state_d = set_req ? OWN_SET : OWN_SEC;
      end
    endcase
    if (alarm_req && (state_q != OWN_ALARM)) begin
      state_d = OWN_ALARM;
    end
    // Any state change starts the new owner's counters from scratch
    if (state_d != state_q) begin
      cnt_d  = 4'd0;
      dir_d  = DIR_UP;
      hold_d = '0;
    end
  end

  // Next bar level and enable for whichever owner holds the bar next cycle
  always_comb begin
    bar_bcd_d = clamp_bcd(sec_ones);
    bar_en_d  = 1'b1;
    case (state_d)
      OWN_ALARM: bar_bcd_d = cnt_d;
      OWN_SET: begin
        bar_bcd_d = clamp_bcd(set_val);
        bar_en_d  = ~blink;
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OWN_SEC;
      cnt_q     <= 4'd0;
      dir_q     <= DIR_UP;
      hold_q    <= '0;
      set_req_q <= 1'b0;
      bar_bcd_q <= 4'd0;
      bar_en_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      hold_q    <= hold_d;
      set_req_q <= set_req;
      bar_bcd_q <= bar_bcd_d;
      bar_en_q  <= bar_en_d;
      ack_q     <= ack_d;
    end
  end

  assign bar_bcd   = bar_bcd_q;
  assign bar_en    = bar_en_q;
  assign owner     = state_q;
  assign alarm_ack = ack_q;

endmodule

// File: tb/tb_led_bar_scheduler.sv
// tb/tb_led_bar_scheduler.sv - scoreboard bench for led_bar_scheduler
module tb_led_bar_scheduler;

  localparam int BDIV = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] sec_ones;
  logic       set_req;
  logic [3:0] set_val;
  logic       alarm_req;
  logic [3:0] bar_bcd;
  logic       bar_en;
  logic [1:0] owner;
  logic       alarm_ack;

  int errors = 0;
  int checks = 0;
  int sticks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got, e;

  always #5 clk = ~clk;

  led_bar_scheduler #(
    .HOLD_TICKS(3),
    .BLINK_DIV (BDIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .sec_ones (sec_ones),
    .set_req  (set_req),
    .set_val  (set_val),
    .alarm_req(alarm_req),
    .bar_bcd  (bar_bcd),
    .bar_en   (bar_en),
    .owner    (owner),
    .alarm_ack(alarm_ack)
  );

  function automatic logic [7:0] pk(input int b, input logic en, input int o, input logic a);
    logic [3:0] b4;
    logic [1:0] o2;
    b4 = b[3:0];
    o2 = o[1:0];
    return {b4, en, o2, a};
  endfunction

  // bar_en in SET after k ticks since entry
  function automatic logic en_of(input int k);
    return ((k / BDIV) % 2) == 0;
  endfunction

  task automatic push_ramp(input int a, input int b, input int own);
    if (a <= b) for (int v = a; v <= b; v++) exp_q.push_back(pk(v, 1'b1, own, 1'b0));
    else        for (int v = a; v >= b; v--) exp_q.push_back(pk(v, 1'b1, own, 1'b0));
  endtask

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; sec_ones = 4'd0; set_req = 1'b0; set_val = 4'd0; alarm_req = 1'b0;
    exp_q.push_back(pk(0, 1'b0, 0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset got=%b exp=%b (bcd,en,own,ack)", got, e); end
    rst_n = 1'b1;
  endtask

  task automatic test_sec();
    int vals[3] = '{7, 2, 9};
    for (int i = 0; i < 3; i++) begin
      sec_ones = vals[i][3:0];
      exp_q.push_back(pk(vals[i], 1'b1, 0, 1'b0));
      cyc(1'b0);
      got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL sec_digit got=%b exp=%b (bcd,en,own,ack)", got, e); end
    end
  endtask

  task automatic test_set_blink();
    set_val = 4'd4; set_req = 1'b1; sticks = 0;
    exp_q.push_back(pk(4, 1'b1, 1, 1'b0));
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL set_entry got=%b exp=%b (bcd,en,own,ack)", got, e); end
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(pk(4, en_of(k - 1), 1, 1'b0));
      exp_q.push_back(pk(4, en_of(k), 1, 1'b0));
      cyc(1'b0);
      got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL set_idle got=%b exp=%b (bcd,en,own,ack)", got, e); end
      cyc(1'b1); sticks++;
      got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL set_blink got=%b exp=%b (bcd,en,own,ack)", got, e); end
    end
    set_val = 4'hB;
    exp_q.push_back(pk(9, en_of(sticks), 1, 1'b0));
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL set_clamp got=%b exp=%b (bcd,en,own,ack)", got, e); end
  endtask

  task automatic test_hold();
    sec_ones = 4'd3; set_req = 1'b0;
    exp_q.push_back(pk(9, en_of(sticks), 1, 1'b0));
    for (int k = 1; k <= 3; k++) exp_q.push_back(pk(9, en_of(sticks + k), 1, 1'b0));
    exp_q.push_back(pk(3, 1'b1, 0, 1'b0));
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL hold_load got=%b exp=%b (bcd,en,own,ack)", got, e); end
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b1); sticks++;
      got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL hold_tick%0d got=%b exp=%b (bcd,en,own,ack)", k, got, e); end
    end
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL hold_exit got=%b exp=%b (bcd,en,own,ack)", got, e); end
  endtask

  task automatic test_hold_cancel();
    logic sr_tab[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic tk_tab[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    set_val = 4'd6; set_req = 1'b1; sticks = 0;
    exp_q.push_back(pk(6, 1'b1, 1, 1'b0));
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL cancel_entry got=%b exp=%b (bcd,en,own,ack)", got, e); end
    for (int i = 0; i < 8; i++) begin
      set_req = sr_tab[i];
      if (tk_tab[i]) sticks++;
      exp_q.push_back(pk(6, en_of(sticks), 1, 1'b0));
      cyc(tk_tab[i]);
      got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL cancel_step%0d got=%b exp=%b (bcd,en,own,ack)", i, got, e); end
    end
    exp_q.push_back(pk(3, 1'b1, 0, 1'b0));
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL cancel_exit got=%b exp=%b (bcd,en,own,ack)", got, e); end
  endtask

  task automatic test_alarm_sweep();
    set_val = 4'd5; set_req = 1'b1;
    exp_q.push_back(pk(5, 1'b1, 1, 1'b0));
    exp_q.push_back(pk(0, 1'b1, 2, 1'b0));
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL sweep_set got=%b exp=%b (bcd,en,own,ack)", got, e); end
    alarm_req = 1'b1;
    cyc(1'b0);
    alarm_req = 1'b0;
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL sweep_entry got=%b exp=%b (bcd,en,own,ack)", got, e); end
    push_ramp(1, 9, 2);
    push_ramp(8, 0, 2);
    for (int i = 0; i < 18; i++) begin
      cyc(1'b0);
      cyc(1'b1);
      got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL sweep_step%0d got=%b exp=%b (bcd,en,own,ack)", i, got, e); end
    end
    exp_q.push_back(pk(5, 1'b1, 1, 1'b1));
    exp_q.push_back(pk(5, 1'b1, 1, 1'b0));
    cyc(1'b1);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL sweep_ack got=%b exp=%b (bcd,en,own,ack)", got, e); end
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL sweep_ack_once got=%b exp=%b (bcd,en,own,ack)", got, e); end
  endtask

  task automatic test_alarm_hold();
    alarm_req = 1'b1;
    exp_q.push_back(pk(0, 1'b1, 2, 1'b0));
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rehold_entry got=%b exp=%b (bcd,en,own,ack)", got, e); end
    push_ramp(1, 9, 2); push_ramp(8, 0, 2); push_ramp(1, 9, 2); push_ramp(8, 4, 2);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1);
      got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL rehold_step%0d got=%b exp=%b (bcd,en,own,ack)", i, got, e); end
    end
    alarm_req = 1'b0; set_req = 1'b0; sec_ones = 4'd3;
    push_ramp(3, 0, 2);
    exp_q.push_back(pk(3, 1'b1, 0, 1'b1));
    exp_q.push_back(pk(3, 1'b1, 0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL rehold_tail%0d got=%b exp=%b (bcd,en,own,ack)", i, got, e); end
    end
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rehold_done got=%b exp=%b (bcd,en,own,ack)", got, e); end
  endtask

  task automatic test_clamp_reset();
    sec_ones = 4'hC;
    exp_q.push_back(pk(9, 1'b1, 0, 1'b0));
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL sec_clamp got=%b exp=%b (bcd,en,own,ack)", got, e); end
    set_req = 1'b1; alarm_req = 1'b1;
    exp_q.push_back(pk(0, 1'b1, 2, 1'b0));
    push_ramp(1, 3, 2);
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL both_req got=%b exp=%b (bcd,en,own,ack)", got, e); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL mid_sweep%0d got=%b exp=%b (bcd,en,own,ack)", i, got, e); end
    end
    #2;
    rst_n = 1'b0;
    exp_q.push_back(pk(0, 1'b0, 0, 1'b0));
    exp_q.push_back(pk(0, 1'b0, 0, 1'b0));
    exp_q.push_back(pk(9, 1'b1, 0, 1'b0));
    #1;
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL async_reset got=%b exp=%b (bcd,en,own,ack)", got, e); end
    alarm_req = 1'b0; set_req = 1'b0;
    cyc(1'b1);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_hold got=%b exp=%b (bcd,en,own,ack)", got, e); end
    rst_n = 1'b1;
    cyc(1'b0);
    got = {bar_bcd, bar_en, owner, alarm_ack}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL post_reset got=%b exp=%b (bcd,en,own,ack)", got, e); end
  endtask

  initial begin
    test_reset();
    test_sec();
    test_set_blink();
    test_hold();
    test_hold_cancel();
    test_alarm_sweep();
    test_alarm_hold();
    test_clamp_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
